// File: rtl/parity_gen.sv
`default_nettype none
// ============================================================================
// Module      : parity_gen
// Description : UART transmit parity-bit generator. Reduces one data word to
//               its parity bit according to a 2-bit mode select, and presents
//               the result from a single output flop for the TX framer.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_gen #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [1:0]            parity_type,
  output logic                  parity_bit
);

  // Mode encodings; 2'b00 and 2'b11 both mean "no parity".
  localparam logic [1:0] MODE_ODD  = 2'b01;
  localparam logic [1:0] MODE_EVEN = 2'b10;

  // Idle/mark level, used both in reset and for the no-parity modes so the
  // framer sends a harmless stop-like bit if it inserts the slot anyway.
  localparam logic MARK_LEVEL = 1'b1;

  logic data_xor;
  logic parity_d;
  logic parity_q;

  // XOR-reduce the word: 1 when the number of ones is odd. For a one-bit
  // word this is simply data_in[0].
  always_comb begin
    data_xor = ^data_in;
  end

  // Select the next parity value from the mode; mark level by default.
  always_comb begin
    parity_d = MARK_LEVEL;
    case (parity_type)
      MODE_ODD:  parity_d = ~data_xor;
      MODE_EVEN: parity_d = data_xor;
      default:   parity_d = MARK_LEVEL;
    endcase
  end

  // Output register; reset forces mark level immediately and drops any
  // value that was about to be captured.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_q <= MARK_LEVEL;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_bit = parity_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_gen
// Description : Self-checking bench for parity_gen (DATA_WIDTH = 8). Expected
//               parity values are queued as stimulus is applied and compared
//               one clock later when the output flop has updated.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_gen;

  localparam int DW = 8;

  logic          clock;
  logic          reset;
  logic [DW-1:0] data_in;
  logic [1:0]    parity_type;
  logic          parity_bit;

  int n_asserts;
  int n_fails;

  logic exp_q[$];

  parity_gen #(.DATA_WIDTH(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .data_in     (data_in),
    .parity_type (parity_type),
    .parity_bit  (parity_bit)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: count ones and derive the bit from the mode definition.
  function automatic logic model(input logic [DW-1:0] d, input logic [1:0] t);
    int ones;
    ones = $countones(d);
    if (t == 2'b01) return (ones % 2 == 0) ? 1'b1 : 1'b0;   // odd total
    if (t == 2'b10) return (ones % 2 == 1) ? 1'b1 : 1'b0;   // even total
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed parity_bit=%b expected %b", tag, obs, exp);
    end
  endtask

  // Apply a word/mode on the falling edge and queue its expected parity.
  task automatic drive(input logic [DW-1:0] d, input logic [1:0] t);
    @(negedge clock);
    data_in     = d;
    parity_type = t;
    exp_q.push_back(model(d, t));
  endtask

  // Wait for the capturing edge, then compare against the oldest expectation.
  task automatic sample(input string tag);
    logic e;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      n_asserts++;
      n_fails++;
      $error("FAIL %s: scoreboard empty, observed parity_bit=%b expected a queued value", tag, parity_bit);
    end else begin
      e = exp_q.pop_front();
      check(tag, parity_bit, e);
    end
  endtask

  initial begin
    n_asserts = 0;
    n_fails   = 0;

    // Reset applied with no clock edge yet: output must already be mark.
    reset       = 1'b1;
    data_in     = 8'b00010111;
    parity_type = 2'b00;
    #1;
    check("reset_immediate", parity_bit, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    check("reset_held", parity_bit, 1'b1);

    // Release reset away from the edge.
    @(negedge clock);
    reset = 1'b0;

    // No-parity modes.
    drive(8'b00001111, 2'b00);
    sample("none_00");
    drive(8'b10111101, 2'b11);
    sample("none_11");

    // Odd mode.
    drive(8'b10101111, 2'b01);
    sample("odd_6ones");
    drive(8'b00000001, 2'b01);
    sample("odd_1one");

    // Even mode.
    drive(8'b10101001, 2'b10);
    sample("even_4ones");
    drive(8'b10000000, 2'b10);
    sample("even_1one");

    // Latency: output holds the old value (1) until the next edge.
    drive(8'b00000001, 2'b01);
    #1;
    check("latency_hold_a", parity_bit, 1'b1);
    sample("latency_new_a");

    // Simultaneous data and mode change: even/10101001 -> odd/11111110.
    drive(8'b10101001, 2'b10);
    sample("simul_prev");
    drive(8'b11111110, 2'b01);
    #1;
    check("simul_hold", parity_bit, 1'b0);
    sample("simul_new");

    // Mid-operation reset: odd mode, data 0 gives parity 1.
    drive(8'b00000000, 2'b01);
    sample("midrst_before");
    @(negedge clock);
    data_in = 8'b00000001;
    reset   = 1'b1;
    #1;
    check("midrst_immediate", parity_bit, 1'b1);
    @(posedge clock);
    #1;
    check("midrst_edge", parity_bit, 1'b1);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    exp_q.push_back(model(data_in, parity_type));
    sample("midrst_release");

    // Random words across all modes, back to back.
    for (int i = 0; i < 16; i++) begin
      drive(DW'($urandom), 2'($urandom_range(0, 3)));
      sample("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
